// File: rtl/fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// fetch_stage_pkg
// Shared definitions for the Fetch stage and its consumers (Decode imports the
// same package, so the {pc, instr} packet layout is defined in one place).
//   - widths, reset PC default, credit limit
//   - RV32 major opcode constants
//   - fetch FSM state enum, packet struct, small helper functions
// -----------------------------------------------------------------------------
package fetch_stage_pkg;

    localparam int ADDR_WIDTH            = 32;
    localparam int INSTR_WIDTH           = 32;
    localparam int IF_PKT_WIDTH          = ADDR_WIDTH + INSTR_WIDTH;
    localparam int MAX_OUTSTAND_DEFAULT  = 2;

    localparam logic [ADDR_WIDTH-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // RV32 major opcodes (instr[6:0]), consumed by Decode.
    localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
    localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;
    localparam logic [6:0] OPC_AUIPC  = 7'b001_0111;
    localparam logic [6:0] OPC_STORE  = 7'b010_0011;
    localparam logic [6:0] OPC_OP     = 7'b011_0011;
    localparam logic [6:0] OPC_LUI    = 7'b011_0111;
    localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
    localparam logic [6:0] OPC_JALR   = 7'b110_0111;
    localparam logic [6:0] OPC_JAL    = 7'b110_1111;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,   // first cycle out of reset, no request
        ST_FETCH = 2'd1,   // normal fetching
        ST_DRAIN = 2'd2    // discarding responses that predate a redirect
    } fetch_state_e;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]  pc;
        logic [INSTR_WIDTH-1:0] instr;
    } if_pkt_t;

    function automatic if_pkt_t make_pkt(input logic [ADDR_WIDTH-1:0]  pc,
                                         input logic [INSTR_WIDTH-1:0] instr);
        if_pkt_t p;
        p.pc    = pc;
        p.instr = instr;
        return p;
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] word_align(input logic [ADDR_WIDTH-1:0] addr);
        return {addr[ADDR_WIDTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// -----------------------------------------------------------------------------
// fetch_stage_if
// Bundles every handshake signal around the Fetch stage: the instruction
// memory request/response channel, the redirect from Execute and the packet
// channel to Decode. Signal prefixes are from the Fetch stage's point of view.
//   master : the Fetch stage (drives o_*, samples i_*)
//   slave  : its environment (memory, Execute, Decode)
// -----------------------------------------------------------------------------
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    logic                    o_imem_req;
    logic [ADDR_WIDTH-1:0]   o_imem_addr;
    logic                    i_imem_gnt;
    logic                    i_imem_rvalid;
    logic [INSTR_WIDTH-1:0]  i_imem_rdata;
    logic                    i_branch_taken;
    logic [ADDR_WIDTH-1:0]   i_branch_pc;
    logic                    i_stall;
    logic [IF_PKT_WIDTH-1:0] o_if_pkt_data;
    logic                    o_if_pkt_valid;

    modport master (
        output o_imem_req, o_imem_addr, o_if_pkt_data, o_if_pkt_valid,
        input  i_imem_gnt, i_imem_rvalid, i_imem_rdata,
               i_branch_taken, i_branch_pc, i_stall
    );

    modport slave (
        input  o_imem_req, o_imem_addr, o_if_pkt_data, o_if_pkt_valid,
        output i_imem_gnt, i_imem_rvalid, i_imem_rdata,
               i_branch_taken, i_branch_pc, i_stall
    );

endinterface

// File: rtl/fetch_stage_sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Small single-clock FIFO used by the Fetch stage for the tag FIFO (PCs of
// in-flight requests) and the packet buffer.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_flush    : empty the FIFO this cycle (wins over push and pop)
//   i_push     : write i_data; legal when full if i_pop is also set
//   i_pop      : discard the head entry (ignored when empty)
//   o_data     : head entry (undefined when o_count == 0)
//   o_count    : number of valid entries
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic [CNT_W-1:0] o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_full;
    logic w_empty;
    logic w_do_push;
    logic w_do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_empty   = (r_count == '0);
    // A pop frees the head slot in the same cycle, so push-when-full is fine then.
    assign w_do_push = i_push && (!w_full || i_pop) && !i_flush;
    assign w_do_pop  = i_pop && !w_empty && !i_flush;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    // NOTE: storage is deliberately not reset; entries are only ever read
    // behind o_count, so their power-up contents never reach a consumer.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(i_push && !i_flush && w_full && !i_pop));

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction Fetch: owns the PC, issues word reads to instruction memory and
// pairs each returned word with the PC it was fetched from. At most
// MAX_OUTSTAND requests in flight plus buffered packets at any time, which is
// exactly what the packet buffer can absorb while Decode stalls.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : fetch_stage_if.master
//     o_imem_req/o_imem_addr/i_imem_gnt     request channel (issue = req && gnt)
//     i_imem_rvalid/i_imem_rdata            in-order responses
//     i_branch_taken/i_branch_pc            redirect pulse from Execute
//     o_if_pkt_valid/o_if_pkt_data/i_stall  {pc, instr} packets to Decode
// -----------------------------------------------------------------------------
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [ADDR_WIDTH-1:0] RESET_PC     = RESET_PC_DEFAULT,
    parameter int                    MAX_OUTSTAND = MAX_OUTSTAND_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_stage_if.master bus
);

    localparam int CNT_W = $clog2(MAX_OUTSTAND + 1);

    fetch_state_e          r_state;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [CNT_W-1:0]      r_drop;

    logic [CNT_W-1:0]      w_drop_next;
    logic [CNT_W-1:0]      w_inflight;
    logic [CNT_W-1:0]      w_buf_count;
    logic [CNT_W:0]        w_credits;
    logic [ADDR_WIDTH-1:0] w_tag_pc;
    if_pkt_t               w_push_pkt;
    if_pkt_t               w_head_pkt;
    logic                  w_req;
    logic                  w_issue;
    logic                  w_resp;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_pkt_valid;

    // ---------------------------------------------------------------- credit
    // Every request in flight already owns a packet-buffer slot, so the buffer
    // can never overflow however long Decode stalls.
    assign w_credits = {1'b0, w_inflight} + {1'b0, w_buf_count};
    assign w_req     = (r_state == ST_FETCH)
                    && (w_credits < (CNT_W + 1)'(MAX_OUTSTAND))
                    && !bus.i_branch_taken;
    assign w_issue   = w_req && bus.i_imem_gnt;

    // A response with nothing in flight is a protocol error; it is ignored.
    assign w_resp    = bus.i_imem_rvalid && (w_inflight != '0);

    // Responses belonging to pre-redirect requests (DRAIN, or the redirect
    // cycle itself) pop their tag but never reach the packet buffer.
    assign w_push     = w_resp && (r_state == ST_FETCH) && !bus.i_branch_taken;
    assign w_push_pkt = make_pkt(w_tag_pc, bus.i_imem_rdata);
    assign w_pop      = w_pkt_valid && !bus.i_stall;

    // Number of responses still to be discarded after this cycle.
    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_drop_next = r_drop;
        if (bus.i_branch_taken) begin
            w_drop_next = w_inflight + CNT_W'(w_issue) - CNT_W'(w_resp);
        end else if ((r_state == ST_DRAIN) && w_resp) begin
            w_drop_next = r_drop - CNT_W'(1);
        end
    end

    // ------------------------------------------------------- FSM / PC / drop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_BOOT;
            r_pc    <= RESET_PC;
            r_drop  <= '0;
        end else begin
            case (r_state)
                ST_BOOT:  r_state <= ST_FETCH;
                ST_FETCH: if (bus.i_branch_taken && (w_drop_next != '0)) r_state <= ST_DRAIN;
                ST_DRAIN: if (w_drop_next == '0) r_state <= ST_FETCH;
                default:  r_state <= ST_BOOT;
            endcase

            r_drop <= w_drop_next;

            if (bus.i_branch_taken) begin
                r_pc <= word_align(bus.i_branch_pc);
            end else if (w_issue) begin
                r_pc <= r_pc + ADDR_WIDTH'(4);   // wraps modulo 2^32
            end
        end
    end

    // ------------------------------------------------------------ storage
    sync_fifo #(
        .WIDTH (ADDR_WIDTH),
        .DEPTH (MAX_OUTSTAND)
    ) u_tag_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (1'b0),           // stale tags are retired by their responses
        .i_push  (w_issue),
        .i_data  (r_pc),
        .i_pop   (w_resp),
        .o_data  (w_tag_pc),
        .o_count (w_inflight)
    );

    sync_fifo #(
        .WIDTH (IF_PKT_WIDTH),
        .DEPTH (MAX_OUTSTAND)
    ) u_pkt_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (bus.i_branch_taken),
        .i_push  (w_push),
        .i_data  (w_push_pkt),
        .i_pop   (w_pop),
        .o_data  (w_head_pkt),
        .o_count (w_buf_count)
    );

    // ------------------------------------------------------------ outputs
    assign w_pkt_valid        = (w_buf_count != '0);
    assign bus.o_imem_req     = w_req;
    assign bus.o_imem_addr    = r_pc;
    assign bus.o_if_pkt_valid = w_pkt_valid;
    // Zero when empty so stale buffer contents never appear on the bus.
    assign bus.o_if_pkt_data  = w_pkt_valid ? w_head_pkt : '0;

    a_rvalid_has_tag: assert property (@(posedge clk) disable iff (!rst_n)
        bus.i_imem_rvalid |-> (w_inflight != '0));

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
// Drives fetch_stage with directed and randomized memory/stall/redirect
// traffic. The reference model is transaction level: a queue of outstanding
// requests (each tagged stale or live), a queue of buffered packets and the
// next fetch PC.
// -----------------------------------------------------------------------------
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct {
        logic [31:0] pc;
        bit          stale;
    } req_t;

    logic clk;
    logic rst_n;

    fetch_stage_if ifc ();

    fetch_stage #(
        .RESET_PC     (RESET_PC),
        .MAX_OUTSTAND (2)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------ bookkeeping
    int n_checks = 0;
    int n_pass   = 0;

    // reference model
    req_t        q[$];        // outstanding requests, oldest first
    logic [63:0] buf_q[$];    // packets waiting for Decode
    logic [31:0] m_pc;
    bit          m_boot;

    // observations from the most recent step
    logic        obs_req;
    logic [31:0] obs_addr;
    logic        obs_valid;
    logic [63:0] obs_data;
    bit          obs_gnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int stale_count();
        int n = 0;
        foreach (q[i]) if (q[i].stale) n++;
        return n;
    endfunction

    task automatic drive_idle();
        ifc.i_imem_gnt     = 1'b0;
        ifc.i_imem_rvalid  = 1'b0;
        ifc.i_imem_rdata   = '0;
        ifc.i_branch_taken = 1'b0;
        ifc.i_branch_pc    = '0;
        ifc.i_stall        = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        drive_idle();
        #1;
        check("rst_req",   64'(ifc.o_imem_req),     64'd0);
        check("rst_addr",  64'(ifc.o_imem_addr),    64'(RESET_PC));
        check("rst_valid", 64'(ifc.o_if_pkt_valid), 64'd0);
        check("rst_data",  ifc.o_if_pkt_data,       64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        buf_q.delete();
        m_pc   = RESET_PC;
        m_boot = 1'b1;
    endtask

    // One clock cycle; entered and left at a falling edge. Percentages choose
    // grant, response, stall and redirect for this cycle.
    task automatic step(input int gnt_p, input int rv_p, input int stall_p,
                        input int br_p, input logic [31:0] br_tgt);
        bit          do_gnt, do_rv, do_stall, do_br;
        logic [31:0] rdata;
        bit          exp_req, exp_valid;
        req_t        e;

        do_gnt   = int'($urandom_range(0, 99)) < gnt_p;
        do_rv    = (q.size() > 0) && (int'($urandom_range(0, 99)) < rv_p);
        do_stall = int'($urandom_range(0, 99)) < stall_p;
        do_br    = int'($urandom_range(0, 99)) < br_p;
        rdata    = $urandom();

        ifc.i_imem_gnt     = do_gnt;
        ifc.i_imem_rvalid  = do_rv;
        ifc.i_imem_rdata   = rdata;
        ifc.i_stall        = do_stall;
        ifc.i_branch_taken = do_br;
        ifc.i_branch_pc    = br_tgt;
        #1;

        obs_req   = ifc.o_imem_req;
        obs_addr  = ifc.o_imem_addr;
        obs_valid = ifc.o_if_pkt_valid;
        obs_data  = ifc.o_if_pkt_data;
        obs_gnt   = do_gnt;

        // A request may go out only when nothing stale is pending and the
        // in-flight plus buffered total leaves room for one more packet.
        exp_req   = !m_boot && (stale_count() == 0) && (q.size() + buf_q.size() < 2) && !do_br;
        exp_valid = buf_q.size() != 0;
        check("req",   64'(obs_req),   64'(exp_req));
        check("addr",  64'(obs_addr),  64'(m_pc));
        check("valid", 64'(obs_valid), 64'(exp_valid));
        check("data",  obs_data,       exp_valid ? buf_q[0] : 64'd0);

        // model update for the coming rising edge
        if (exp_valid && !do_stall) void'(buf_q.pop_front());
        if (do_rv) begin
            e = q.pop_front();
            if (!e.stale && !do_br) buf_q.push_back({e.pc, rdata});
        end
        if (do_br) begin
            buf_q.delete();
            foreach (q[i]) q[i].stale = 1'b1;
            m_pc = {br_tgt[31:2], 2'b00};
        end else if (exp_req && do_gnt) begin
            q.push_back(req_t'{pc: m_pc, stale: 1'b0});
            m_pc = m_pc + 32'd4;
        end
        m_boot = 1'b0;

        @(negedge clk);
    endtask

    // ------------------------------------------------------------ stimulus
    initial begin
        int  first_valid;
        bit  found;
        bit  saw_top;

        drive_idle();
        rst_n = 1'b1;
        #2;
        apply_reset();

        // 1: back-to-back fetch, minimum latency
        first_valid = -1;
        for (int k = 0; k < 12; k++) begin
            step(100, 100, 0, 0, 32'h0);
            if (obs_valid && first_valid < 0) begin
                first_valid = k;
                check("first_pkt_pc", 64'(obs_data[63:32]), 64'(RESET_PC));
            end else if (obs_valid && k == first_valid + 1) begin
                check("second_pkt_pc", 64'(obs_data[63:32]), 64'(RESET_PC + 32'd4));
            end
        end
        check("first_pkt_cycle", 64'(first_valid), 64'd3);

        // 2: Decode stalls for 5 cycles under a steady response stream
        repeat (5)  step(100, 100, 100, 0, 32'h0);
        check("stall_buf_full_valid", 64'(obs_valid), 64'd1);
        repeat (10) step(100, 100, 0, 0, 32'h0);

        // 3: redirect to an unaligned target with two requests in flight
        for (int k = 0; k < 20 && q.size() < 2; k++) step(100, 0, 0, 0, 32'h0);
        check("two_inflight_reached", 64'(q.size()), 64'd2);
        step(0, 0, 0, 100, 32'h0000_0103);
        step(100, 100, 0, 0, 32'h0);
        check("redirect_addr", 64'(obs_addr), 64'h100);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            step(100, 100, 0, 0, 32'h0);
            if (obs_valid) begin
                found = 1'b1;
                check("redirect_first_pc", 64'(obs_data[63:32]), 64'h100);
            end
        end
        if (!found) check("redirect_pkt_timeout", 64'd0, 64'd1);

        // 4: redirect coinciding with a response and a grant
        for (int k = 0; k < 20 && q.size() < 2; k++) step(100, 0, 0, 0, 32'h0);
        check("two_inflight_reached2", 64'(q.size()), 64'd2);
        step(100, 100, 0, 100, 32'h0000_2000);
        step(100, 0, 0, 0, 32'h0);
        check("drain_req_low", 64'(obs_req), 64'd0);
        repeat (10) step(100, 100, 0, 0, 32'h0);

        // 5: PC wrap at the top of the address space
        step(100, 100, 0, 100, 32'hFFFF_FFFC);
        saw_top = 1'b0;
        found   = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            step(100, 100, 0, 0, 32'h0);
            if (obs_req && obs_gnt) begin
                if (saw_top) begin
                    check("wrap_addr", 64'(obs_addr), 64'h0);
                    found = 1'b1;
                end else if (obs_addr == 32'hFFFF_FFFC) begin
                    saw_top = 1'b1;
                end
            end
        end
        if (!found) check("wrap_timeout", 64'd0, 64'd1);
        repeat (6) step(100, 100, 0, 0, 32'h0);

        // 6: randomized traffic with occasional redirects
        for (int k = 0; k < 600; k++) step(70, 60, 30, 4, $urandom());

        // 7: reset asserted mid-stream with a full packet buffer
        repeat (8) step(100, 100, 100, 0, 32'h0);
        check("full_before_reset", 64'(obs_valid), 64'd1);
        #3;
        apply_reset();
        found = 1'b0;
        for (int k = 0; k < 5 && !found; k++) begin
            step(100, 100, 0, 0, 32'h0);
            if (obs_req) begin
                found = 1'b1;
                check("post_reset_first_addr", 64'(obs_addr), 64'(RESET_PC));
                check("post_reset_first_cycle", 64'(k), 64'd1);
            end
        end
        if (!found) check("post_reset_req_timeout", 64'd0, 64'd1);
        repeat (10) step(100, 100, 0, 0, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: observed no completion, expected finish before %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
